// File: rtl/adder_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : adder_pkg
//  Description : Shared types and constants for the digit-serial adder
//                sequencer (serial_add_ctrl) and its 2-bit slice.
//  Revision    : 1.0 - initial release
// ============================================================================
package adder_pkg;

   // Bits consumed per RUN cycle by the shared ripple slice
   localparam int SLICE_W = 2;

   // Sequencer states
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } add_state_t;

endpackage
`default_nettype wire

// File: rtl/serial_add_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : serial_add_ctrl_if
//  Description : Operand-in / result-out handshake bundle of serial_add_ctrl.
//                The slave modport is the adder's view; master is the view of
//                the combined operand source and result consumer.
//                Optional port ovf exists when SERIAL_ADD_OVF_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
interface serial_add_ctrl_if #(
   parameter int WIDTH = 16
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             busy;
`ifdef SERIAL_ADD_OVF_EN
   logic             ovf;

   modport slave (
      input  in_valid, a, b, cin, out_ready,
      output in_ready, out_valid, sum, cout, busy, ovf
   );
   modport master (
      output in_valid, a, b, cin, out_ready,
      input  in_ready, out_valid, sum, cout, busy, ovf
   );
`else
   modport slave (
      input  in_valid, a, b, cin, out_ready,
      output in_ready, out_valid, sum, cout, busy
   );
   modport master (
      output in_valid, a, b, cin, out_ready,
      input  in_ready, out_valid, sum, cout, busy
   );
`endif
endinterface
`default_nettype wire

// File: rtl/adder_slice2.sv
`default_nettype none
// ============================================================================
//  Module      : adder_slice2
//  Description : Combinational 2-bit ripple adder built from two full-adder
//                cells. The carry between the two cells is exported so the
//                sequencer can derive signed overflow from the MSB slice.
//  Revision    : 1.0 - initial release
// ============================================================================
module adder_slice2
   import adder_pkg::*;
(
   input  logic [SLICE_W-1:0] a_i,
   input  logic [SLICE_W-1:0] b_i,
   input  logic               c_i,
   output logic [SLICE_W-1:0] s_o,
   output logic               c_mid_o,
   output logic               c_o
);

   logic [SLICE_W:0] w_c;

   assign w_c[0] = c_i;

   // One full-adder cell per bit, rippling the carry upward
   for (genvar i = 0; i < SLICE_W; i++) begin : g_fa
      assign s_o[i]   = a_i[i] ^ b_i[i] ^ w_c[i];
      assign w_c[i+1] = (a_i[i] & b_i[i]) | (w_c[i] & (a_i[i] ^ b_i[i]));
   end

   assign c_mid_o = w_c[1];
   assign c_o     = w_c[SLICE_W];

endmodule
`default_nettype wire

// File: rtl/serial_add_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : serial_add_ctrl
//  Description : Digit-serial adder sequencer. Accepts one WIDTH-bit operand
//                pair plus carry-in, adds it two bits per cycle through a
//                single adder_slice2, and presents sum/cout on a result
//                handshake. WIDTH must be even and >= 2.
//                Define SERIAL_ADD_OVF_EN to add the signed-overflow output.
//  Revision    : 1.0 - initial release
// ============================================================================
module serial_add_ctrl
   import adder_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   serial_add_ctrl_if.slave bus
);

   localparam int N     = WIDTH / SLICE_W;
   localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

   add_state_t        state_q, state_d;
   logic [WIDTH-1:0]  a_q, b_q, sum_q;
   logic              carry_q;
   logic              cout_q;
   logic [CNT_W-1:0]  cnt_q;

   logic              w_accept;
   logic              w_last;
   logic [SLICE_W-1:0] w_slice_s;
   logic              w_slice_mid;
   logic              w_slice_c;

   assign w_accept = bus.in_valid && (state_q == IDLE);
   assign w_last   = (state_q == RUN) && (cnt_q == CNT_LAST);

   // The one shared slice always looks at the low digit of the shifting operands
   adder_slice2 u_slice (
      .a_i     (a_q[SLICE_W-1:0]),
      .b_i     (b_q[SLICE_W-1:0]),
      .c_i     (carry_q),
      .s_o     (w_slice_s),
      .c_mid_o (w_slice_mid),
      .c_o     (w_slice_c)
   );

   // State register
   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // Next-state logic: accept in IDLE, N slice cycles in RUN, hold in DONE
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (w_accept)      state_d = RUN;
         RUN:     if (w_last)        state_d = DONE;
         DONE:    if (bus.out_ready) state_d = IDLE;
         default:                    state_d = IDLE;
      endcase
   end

   // Operand shifters, carry, digit counter and result assembly
   always_ff @(posedge clk) begin
      if (rst) begin
         a_q     <= '0;
         b_q     <= '0;
         carry_q <= 1'b0;
         cnt_q   <= '0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
      end else if (w_accept) begin
         a_q     <= bus.a;
         b_q     <= bus.b;
         carry_q <= bus.cin;
         cnt_q   <= '0;
      end else if (state_q == RUN) begin
         a_q     <= a_q >> SLICE_W;
         b_q     <= b_q >> SLICE_W;
         carry_q <= w_slice_c;
         cnt_q   <= cnt_q + 1'b1;
         sum_q[SLICE_W*cnt_q +: SLICE_W] <= w_slice_s;
         if (w_last) cout_q <= w_slice_c;
      end
   end

`ifdef SERIAL_ADD_OVF_EN
   logic ovf_q;

   // Signed overflow: carry into the MSB differs from carry out of it
   always_ff @(posedge clk) begin
      if (rst)         ovf_q <= 1'b0;
      else if (w_last) ovf_q <= w_slice_mid ^ w_slice_c;
   end

   assign bus.ovf = ovf_q;
`else
   logic w_unused_mid;
   assign w_unused_mid = w_slice_mid;
`endif

   assign bus.in_ready  = (state_q == IDLE);
   assign bus.out_valid = (state_q == DONE);
   assign bus.busy      = (state_q != IDLE);
   assign bus.sum       = sum_q;
   assign bus.cout      = cout_q;

endmodule
`default_nettype wire

// File: tb/tb_serial_add_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_serial_add_ctrl
//  Description : Self-checking bench for serial_add_ctrl (WIDTH=16 and
//                WIDTH=2 instances). Checks ovf when SERIAL_ADD_OVF_EN is set.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_serial_add_ctrl;

   localparam int W = 16;
   localparam int N = W / 2;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   serial_add_ctrl_if #(.WIDTH(W)) bus  ();
   serial_add_ctrl_if #(.WIDTH(2)) bus2 ();

   serial_add_ctrl #(.WIDTH(W)) dut  (.clk(clk), .rst(rst), .bus(bus.slave));
   serial_add_ctrl #(.WIDTH(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2.slave));

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic        cin;
      logic [15:0] s;
      logic        c;
      logic        o;
   } vec_t;

   vec_t tbl[8];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Reference: plain arithmetic, result = {ovf, cout, sum}
   function automatic logic [17:0] model16(input logic [15:0] a, input logic [15:0] b, input logic cin);
      logic [16:0] t;
      logic        o;
      t = {1'b0, a} + {1'b0, b} + {16'd0, cin};
      o = (a[15] == b[15]) && (t[15] != a[15]);
      return {o, t};
   endfunction

   // One full WIDTH=16 transaction with operand scrambling during RUN
   task automatic op16(input string tag, input logic [15:0] a, input logic [15:0] b, input logic cin,
                       input int hold, input logic [15:0] es, input logic ec, input logic eo);
      int k;
      @(negedge clk);
      check({tag, "_in_ready"}, bus.in_ready, 1);
      bus.in_valid = 1'b1; bus.a = a; bus.b = b; bus.cin = cin;
      @(negedge clk);
      k = 1;
      bus.in_valid = 1'b0; bus.a = 16'hAAAA; bus.b = 16'($urandom); bus.cin = 1'($urandom);
      check({tag, "_busy"}, bus.busy, 1);
      while (!bus.out_valid && k < 4*N) begin
         @(negedge clk);
         k++;
         bus.a = 16'($urandom); bus.b = 16'($urandom);
      end
      check({tag, "_latency"}, k, N + 1);
      check({tag, "_sum"}, bus.sum, es);
      check({tag, "_cout"}, bus.cout, ec);
`ifdef SERIAL_ADD_OVF_EN
      check({tag, "_ovf"}, bus.ovf, eo);
`endif
      repeat (hold) begin
         @(negedge clk);
         check({tag, "_hold_valid"}, bus.out_valid, 1);
         check({tag, "_hold_sum"}, bus.sum, es);
      end
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0;
      check({tag, "_drop"}, bus.out_valid, 0);
   endtask

   // One WIDTH=2 transaction
   task automatic op2(input logic [1:0] a, input logic [1:0] b, input logic cin);
      int k;
      int t;
      logic [1:0] es;
      t  = int'(a) + int'(b) + int'(cin);
      es = 2'(t % 4);
      @(negedge clk);
      bus2.in_valid = 1'b1; bus2.a = a; bus2.b = b; bus2.cin = cin;
      @(negedge clk);
      k = 1;
      bus2.in_valid = 1'b0; bus2.a = ~a; bus2.b = ~b;
      while (!bus2.out_valid && k < 8) begin
         @(negedge clk);
         k++;
      end
      check("w2_latency", k, 2);
      check("w2_sum", bus2.sum, es);
      check("w2_cout", bus2.cout, (t >= 4));
`ifdef SERIAL_ADD_OVF_EN
      check("w2_ovf", bus2.ovf, (a[1] == b[1]) && (es[1] != a[1]));
`endif
      bus2.out_ready = 1'b1;
      @(negedge clk);
      bus2.out_ready = 1'b0;
      check("w2_drop", bus2.out_valid, 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [17:0] m;
      logic [15:0] ra, rb;
      logic        rc;
      int          k;

      tbl[0] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
      tbl[1] = '{16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 1'b0};
      tbl[2] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
      tbl[3] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
      tbl[4] = '{16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0};
      tbl[5] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
      tbl[6] = '{16'hAAAA, 16'h5555, 1'b1, 16'h0000, 1'b1, 1'b0};
      tbl[7] = '{16'h8000, 16'h7FFF, 1'b0, 16'hFFFF, 1'b0, 1'b0};

      rst = 1'b1;
      bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.cin = 1'b0; bus.out_ready = 1'b0;
      bus2.in_valid = 1'b0; bus2.a = '0; bus2.b = '0; bus2.cin = 1'b0; bus2.out_ready = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;

      check("rst_in_ready", bus.in_ready, 1);
      check("rst_out_valid", bus.out_valid, 0);
      check("rst_busy", bus.busy, 0);
      check("rst_sum", bus.sum, 0);
      check("rst_cout", bus.cout, 0);
`ifdef SERIAL_ADD_OVF_EN
      check("rst_ovf", bus.ovf, 0);
`endif

      for (int i = 0; i < 8; i++)
         op16($sformatf("tbl%0d", i), tbl[i].a, tbl[i].b, tbl[i].cin, i % 3, tbl[i].s, tbl[i].c, tbl[i].o);

      // Back-pressure: result held, new operands wait until after release
      @(negedge clk);
      bus.in_valid = 1'b1; bus.a = 16'h1234; bus.b = 16'h4321; bus.cin = 1'b1;
      @(negedge clk);
      bus.a = 16'h1111; bus.b = 16'h2222; bus.cin = 1'b0;
      k = 1;
      while (!bus.out_valid && k < 4*N) begin @(negedge clk); k++; end
      check("bp_latency", k, N + 1);
      check("bp_sum", bus.sum, 16'h5556);
      repeat (5) begin
         @(negedge clk);
         check("bp_valid_held", bus.out_valid, 1);
         check("bp_in_ready", bus.in_ready, 0);
         check("bp_sum_held", bus.sum, 16'h5556);
         check("bp_cout_held", bus.cout, 0);
      end
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0;
      check("bp_released_valid", bus.out_valid, 0);
      check("bp_released_idle", bus.busy, 0);
      check("bp_released_ready", bus.in_ready, 1);
      @(negedge clk);
      bus.in_valid = 1'b0;
      check("bp_new_accepted", bus.busy, 1);
      k = 1;
      while (!bus.out_valid && k < 4*N) begin @(negedge clk); k++; end
      check("bp_new_latency", k, N + 1);
      check("bp_new_sum", bus.sum, 16'h3333);
      check("bp_new_cout", bus.cout, 0);
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0;

      // Reset in the 3rd RUN cycle, together with an attempted handshake
      @(negedge clk);
      bus.in_valid = 1'b1; bus.a = 16'h00FF; bus.b = 16'h0F0F; bus.cin = 1'b0;
      @(negedge clk);
      bus.in_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1; bus.in_valid = 1'b1;
      @(negedge clk);
      check("mid_rst_out_valid", bus.out_valid, 0);
      check("mid_rst_busy", bus.busy, 0);
      check("mid_rst_sum", bus.sum, 0);
      check("mid_rst_in_ready", bus.in_ready, 1);
      @(negedge clk);
      check("rst_beats_handshake", bus.busy, 0);
      rst = 1'b0; bus.in_valid = 1'b0;
      op16("after_rst", 16'h0003, 16'h0005, 1'b0, 0, 16'h0008, 1'b0, 1'b0);

      // Randomized operations against the arithmetic model
      for (int i = 0; i < 40; i++) begin
         ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom);
         if (i % 5 == 0) rb = ~ra;
         m = model16(ra, rb, rc);
         op16($sformatf("rnd%0d", i), ra, rb, rc, int'($urandom_range(0, 2)), m[15:0], m[16], m[17]);
      end

      // WIDTH=2 instance: single-cycle RUN
      op2(2'd3, 2'd3, 1'b1);
      for (int i = 0; i < 12; i++)
         op2(2'($urandom), 2'($urandom), 1'($urandom));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/serial_add_ctrl.md
# serial_add_ctrl

Digit-serial adder sequencer. Accepts one WIDTH-bit operand pair plus carry-in over a valid/ready handshake. Adds the pair two bits per cycle through a single 2-bit ripple slice, carrying between slices in a register. Presents the result and carry-out on a second valid/ready handshake. Sits between the operand source and result consumer wherever area matters more than latency, reusing one 2-bit adder slice for any even word width.

## Interface
- `WIDTH`, default 16: operand/result width. Must be even and ≥ 2.
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `in_valid`  in  1: operand pair valid.
- `in_ready`  out  1: block can accept operands.
- `a`  in  WIDTH: operand A, unsigned or two's complement.
- `b`  in  WIDTH: operand B.
- `cin`  in  1: carry-in to bit 0.
- `out_valid`  out  1: result valid.
- `out_ready`  in  1: consumer accepts result.
- `sum`  out  WIDTH: A + B + cin, modulo 2^WIDTH.
- `cout`  out  1: carry out of bit WIDTH-1.
- `busy`  out  1: high in RUN or DONE.
- `ovf`  out  1: signed overflow. Present only when `SERIAL_ADD_OVF_EN` is defined.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - `in_ready`=1.
  - On `in_valid && in_ready`: latch `a`, `b` into shift registers, `cin` into the carry register, and clear slice counter `cnt`. Go to RUN.
- RUN, N = WIDTH/2 cycles:
  - Each cycle, feed the slice with the low 2 bits of A/B and the carry register.
  - Write the 2-bit slice sum into result bits [2·cnt+1 : 2·cnt].
  - Store the slice carry-out in the carry register.
  - Shift A/B right by 2 and increment `cnt`.
  - On the cycle `cnt`==N-1, go to DONE.
- DONE:
  - `out_valid`=1; `sum` and `cout` are stable.
  - On `out_ready`, go to IDLE.
- `in_ready`=0 in RUN and DONE. `in_valid` is ignored there. `a`/`b`/`cin` may change freely after acceptance without affecting the result.
- `cnt` width is clog2(N), minimum 1.
- `sum`/`cout` hold their last value in IDLE. They are undefined to the consumer except while `out_valid`=1.
- `busy` = (state != IDLE).

## Timing
- Reset values: state IDLE, `out_valid`=0, `sum`=0, `cout`=0, `busy`=0, `ovf`=0, carry register 0, `cnt`=0. `in_ready`=1 from the first cycle after reset.
- Latency: handshake accepted at edge 0. RUN occupies cycles 1..N. `out_valid` rises at cycle N+1 (cycle 9 for WIDTH=16).
- Throughput: one operation per N+2 cycles with `out_ready` held high. No back-to-back acceptance in DONE.
- `out_valid` stays high, with `sum`/`cout` frozen, until `out_ready` is sampled high. It drops the cycle after.
- `rst` in any state: returns to IDLE next edge and discards the in-flight operation. `rst` dominates a simultaneous handshake.
- WIDTH=2: RUN lasts exactly one cycle.

## Configuration
- `SERIAL_ADD_OVF_EN` defined:
  - Port `ovf` exists.
  - Registered at the final RUN cycle as the carry-in XOR carry-out of the MSB slice's top bit, i.e. `a[W-1]==b[W-1] && sum[W-1]!=a[W-1]`.
  - Same validity and reset rules as `cout`.
- Not defined: port `ovf` and its logic are absent. All other behaviour is identical.

## Structure
- Package `adder_pkg`:
  - state enum `add_state_t` (IDLE, RUN, DONE).
  - constant `SLICE_W = 2`.
- Sub-module `adder_slice2`: combinational 2-bit ripple adder (A[1:0], B[1:0], Cin → Sum[1:0], Cout) built from two 1-bit full-adder cells.
  - Instantiated once.
  - Exports the internal carry between its two bits for overflow detection.
- FSM, counter, shift and result registers live in `serial_add_ctrl`.

## Test plan
- WIDTH=16, a=0xFFFF, b=0x0001, cin=0 → `sum`=0x0000, `cout`=1, `out_valid` rising 9 cycles after acceptance.
- a=0x1234, b=0x4321, cin=1 → `sum`=0x5556, `cout`=0. Change `a` to 0xAAAA during RUN → result unchanged.
- Hold `out_ready`=0 for 5 cycles in DONE, keep `in_valid`=1 with new operands → `sum` held, `in_ready`=0, new operands not accepted until the cycle after `out_ready`=1.
- Assert `rst` at the 3rd RUN cycle → next cycle IDLE, `out_valid`=0, `sum`=0. A following transaction 0x0003+0x0005 gives 0x0008.
- With `SERIAL_ADD_OVF_EN`: 0x7FFF+0x0001 → `ovf`=1, `cout`=0. 0x8000+0x8000 → `sum`=0, `cout`=1, `ovf`=1. 0x0001+0x0001 → `ovf`=0.
- WIDTH=2: a=3, b=3, cin=1 → `sum`=3, `cout`=1, `out_valid` 2 cycles after acceptance.
